lock_sequencer: RTL and testbench

//  Sequencing FSM for the 2-bit-digit combination lock. Owns the stored password (up to PWD_MAX digits).

---
 rtl/lock_sequencer.sv | 177 +++++++++++++++++
 tb/tb_lock_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lock_sequencer.sv
// Combination-lock sequencer: turns debounced key presses into digit events, checks them
// against a stored 2-bit-digit password, and handles unlock, re-programming and lockout.
module lock_sequencer #(
   parameter int          PWD_MAX     = 7,
   parameter logic [13:0] DEFAULT_PWD = 14'h0E4,
   parameter int          DEFAULT_LEN = 3,
   parameter int          MAX_FAIL    = 3,
   parameter int          LOCKOUT_CYC = 1000
) (
   input  logic       CLK,
   input  logic       CLR_n,
   input  logic       KeyPress,
   input  logic [1:0] KeyValue,
   input  logic       Change,
   input  logic       Lock_It,
   output logic       Unlocked,
   output logic       Programming,
   output logic       Alarm,
   output logic [2:0] DigitCnt,
   output logic [1:0] FailCnt,
   output logic [1:0] state_dbg
);

   localparam int PW = 2 * PWD_MAX;
   localparam int TW = (LOCKOUT_CYC > 2) ? $clog2(LOCKOUT_CYC) : 1;

   // Handshake: none; KeyPress/Change are levels whose 0->1 transitions are single events,
   // Lock_It is a level that wins over both whenever it is high.
   typedef enum logic [1:0] {
      S_LOCKED  = 2'd0,
      S_OPEN    = 2'd1,
      S_PROGRAM = 2'd2,
      S_LOCKOUT = 2'd3
   } state_t;

   state_t          state, state_n;
   logic            key_q, change_q;
   logic [2:0]      digit_cnt, digit_n;
   logic [1:0]      fail_cnt, fail_n;
   logic            mismatch, mism_n;
   logic [PW-1:0]   pwd, pwd_n;
   logic [PW-1:0]   shadow, shadow_n;
   logic [2:0]      pwd_len, len_n;
   logic [TW-1:0]   timer, timer_n;

   logic            key_ev, ch_ev, last_digit, miss;
   logic [1:0]      cur_digit, fail_inc;

   always_comb begin
      key_ev     = KeyPress & ~key_q;
      ch_ev      = Change & ~change_q;
      cur_digit  = pwd[{digit_cnt, 1'b0} +: 2];
      miss       = (KeyValue != cur_digit);
      last_digit = ((digit_cnt + 3'd1) == pwd_len);
      fail_inc   = (fail_cnt == 2'(MAX_FAIL)) ? fail_cnt : fail_cnt + 2'd1;

      state_n  = state;
      digit_n  = digit_cnt;
      fail_n   = fail_cnt;
      mism_n   = mismatch;
      pwd_n    = pwd;
      len_n    = pwd_len;
      shadow_n = shadow;
      timer_n  = timer;

      case (state)
         S_LOCKED: begin
            if (Lock_It) begin
               digit_n = 3'd0;
               mism_n  = 1'b0;
            end else if (key_ev && !ch_ev) begin
               if (last_digit) begin
                  // Whole sequence entered: decide on the accumulated miss flag plus this digit.
                  digit_n = 3'd0;
                  mism_n  = 1'b0;
                  if (!(mismatch | miss)) begin
                     state_n = S_OPEN;
                     fail_n  = 2'd0;
                  end else begin
                     fail_n = fail_inc;
                     if (fail_inc == 2'(MAX_FAIL)) begin
                        state_n = S_LOCKOUT;
                        timer_n = '0;
                     end
                  end
               end else begin
                  digit_n = digit_cnt + 3'd1;
                  mism_n  = mismatch | miss;
               end
            end
         end
         S_OPEN: begin
            if (Lock_It) begin
               state_n = S_LOCKED;
               digit_n = 3'd0;
            end else if (ch_ev) begin
               state_n = S_PROGRAM;
               digit_n = 3'd0;
            end
         end
         S_PROGRAM: begin
            if (Lock_It) begin
               state_n = S_LOCKED;
               digit_n = 3'd0;
            end else if (ch_ev) begin
               if (digit_cnt != 3'd0) begin
                  pwd_n = shadow;
                  len_n = digit_cnt;
               end
               state_n = S_OPEN;
               digit_n = 3'd0;
            end else if (key_ev) begin
               shadow_n[{digit_cnt, 1'b0} +: 2] = KeyValue;
               if ((digit_cnt + 3'd1) == 3'(PWD_MAX)) begin
                  pwd_n   = shadow_n;
                  len_n   = 3'(PWD_MAX);
                  state_n = S_OPEN;
                  digit_n = 3'd0;
               end else begin
                  digit_n = digit_cnt + 3'd1;
               end
            end
         end
         S_LOCKOUT: begin
            if (timer == TW'(LOCKOUT_CYC - 1)) begin
               state_n = S_LOCKED;
               fail_n  = 2'd0;
               digit_n = 3'd0;
               mism_n  = 1'b0;
            end else begin
               timer_n = timer + 1'b1;
            end
         end
         default: begin
            state_n = S_LOCKED;
            digit_n = 3'd0;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge CLR_n) begin
      if (!CLR_n) begin
         state       <= S_LOCKED;
         key_q       <= 1'b0;
         change_q    <= 1'b0;
         digit_cnt   <= 3'd0;
         fail_cnt    <= 2'd0;
         mismatch    <= 1'b0;
         pwd         <= DEFAULT_PWD[PW-1:0];
         pwd_len     <= 3'(DEFAULT_LEN);
         shadow      <= '0;
         timer       <= '0;
         Unlocked    <= 1'b0;
         Programming <= 1'b0;
         Alarm       <= 1'b0;
      end else begin
         state       <= state_n;
         key_q       <= KeyPress;
         change_q    <= Change;
         digit_cnt   <= digit_n;
         fail_cnt    <= fail_n;
         mismatch    <= mism_n;
         pwd         <= pwd_n;
         pwd_len     <= len_n;
         shadow      <= shadow_n;
         timer       <= timer_n;
         Unlocked    <= (state_n == S_OPEN) || (state_n == S_PROGRAM);
         Programming <= (state_n == S_PROGRAM);
         Alarm       <= (state_n == S_LOCKOUT);
      end
   end

   assign DigitCnt  = digit_cnt;
   assign FailCnt   = fail_cnt;
   assign state_dbg = state;

endmodule

// File: tb/tb_lock_sequencer.sv
// Bench for lock_sequencer: directed scenarios plus random key/change/lock traffic, all checked
// every cycle against a queue-based model of the lock's rules.
module tb_lock_sequencer;

   localparam int PWD_MAX     = 7;
   localparam int MAX_FAIL    = 3;
   localparam int LOCKOUT_CYC = 1000;

   // ---------------- clock / reset ----------------
   logic       CLK = 1'b0;
   logic       CLR_n = 1'b0;
   logic       KeyPress = 1'b0;
   logic [1:0] KeyValue = 2'd0;
   logic       Change = 1'b0;
   logic       Lock_It = 1'b0;
   logic       Unlocked, Programming, Alarm;
   logic [2:0] DigitCnt;
   logic [1:0] FailCnt;
   logic [1:0] state_dbg;

   always #5 CLK = ~CLK;

   lock_sequencer dut (
      .CLK(CLK), .CLR_n(CLR_n), .KeyPress(KeyPress), .KeyValue(KeyValue),
      .Change(Change), .Lock_It(Lock_It), .Unlocked(Unlocked), .Programming(Programming),
      .Alarm(Alarm), .DigitCnt(DigitCnt), .FailCnt(FailCnt), .state_dbg(state_dbg)
   );

   int n_cmp = 0;
   int n_err = 0;

   // ---------------- reference model ----------------
   int         pwd_q[$];
   int         ent_q[$];
   int         prog_q[$];
   bit         m_open, m_prog, m_alarm;
   int         m_fail, m_left;
   bit         kp_prev, ch_prev;
   logic [7:0] exp_q[$];

   function automatic bit entry_matches();
      if (ent_q.size() != pwd_q.size()) return 1'b0;
      for (int i = 0; i < ent_q.size(); i++)
         if (ent_q[i] != pwd_q[i]) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [7:0] model_outputs();
      int dig;
      if (m_prog) dig = prog_q.size();
      else if (m_open || m_alarm) dig = 0;
      else dig = ent_q.size();
      return {m_open | m_prog, m_prog, m_alarm, 3'(dig), 2'(m_fail)};
   endfunction

   always @(posedge CLK or negedge CLR_n) begin : model
      bit key_ev, ch_ev;
      if (!CLR_n) begin
         pwd_q = '{0, 1, 2};
         ent_q.delete();
         prog_q.delete();
         m_open = 0; m_prog = 0; m_alarm = 0;
         m_fail = 0; m_left = 0;
         kp_prev = 0; ch_prev = 0;
         exp_q.delete();
         exp_q.push_back(8'h00);
      end else begin
         key_ev  = KeyPress && !kp_prev;
         ch_ev   = Change && !ch_prev;
         kp_prev = KeyPress;
         ch_prev = Change;
         if (m_alarm) begin
            m_left--;
            if (m_left == 0) begin
               m_alarm = 0;
               m_fail  = 0;
               ent_q.delete();
            end
         end else if (m_prog) begin
            if (Lock_It) begin
               m_prog = 0;
            end else if (ch_ev) begin
               if (prog_q.size() > 0) pwd_q = prog_q;
               m_prog = 0; m_open = 1;
            end else if (key_ev) begin
               prog_q.push_back(int'(KeyValue));
               if (prog_q.size() == PWD_MAX) begin
                  pwd_q  = prog_q;
                  m_prog = 0; m_open = 1;
               end
            end
         end else if (m_open) begin
            if (Lock_It) begin
               m_open = 0;
               ent_q.delete();
            end else if (ch_ev) begin
               m_open = 0; m_prog = 1;
               prog_q.delete();
            end
         end else begin
            if (Lock_It) begin
               ent_q.delete();
            end else if (!ch_ev && key_ev) begin
               ent_q.push_back(int'(KeyValue));
               if (ent_q.size() == pwd_q.size()) begin
                  if (entry_matches()) begin
                     m_open = 1;
                     m_fail = 0;
                  end else begin
                     if (m_fail < MAX_FAIL) m_fail++;
                     if (m_fail == MAX_FAIL) begin
                        m_alarm = 1;
                        m_left  = LOCKOUT_CYC;
                     end
                  end
                  ent_q.delete();
               end
            end
         end
         exp_q.push_back(model_outputs());
      end
   end

   // ---------------- scoreboard ----------------
   always @(negedge CLK) begin
      logic [7:0] e, a;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = {Unlocked, Programming, Alarm, DigitCnt, FailCnt};
         n_cmp++;
         if (a !== e) begin
            n_err++;
            $display("FAIL cycle_outputs @%0t: got {unl,prog,alarm,dig,fail}=%b expected %b",
                     $time, a, e);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge CLK);
      #2;
   endtask

   task automatic press(input logic [1:0] v);
      KeyValue = v;
      KeyPress = 1'b1;
      tick();
      KeyPress = 1'b0;
      tick();
   endtask

   task automatic enter(input logic [13:0] code, input int len);
      for (int i = 0; i < len; i++) press(code[2*i +: 2]);
   endtask

   task automatic pulse_change();
      Change = 1'b1;
      tick();
      Change = 1'b0;
      tick();
   endtask

   task automatic pulse_lock();
      Lock_It = 1'b1;
      tick();
      Lock_It = 1'b0;
      tick();
   endtask

   // ---------------- stimulus ----------------
   localparam logic [13:0] CODE_012  = 14'h0024;
   localparam logic [13:0] CODE_013  = 14'h0034;
   localparam logic [13:0] CODE_33   = 14'h000F;
   localparam logic [13:0] CODE_SEV  = 14'h3939;  // 1,2,3,0,1,2,3

   initial begin
      int cnt;
      tick(2);
      check("reset_unlocked", Unlocked, 0);
      check("reset_programming", Programming, 0);
      check("reset_alarm", Alarm, 0);
      check("reset_digitcnt", DigitCnt, 0);
      check("reset_failcnt", FailCnt, 0);
      CLR_n = 1'b1;
      tick();

      // default code opens one cycle after the third rise
      press(2'd0);
      press(2'd1);
      check("t1_digits_before_last", DigitCnt, 2);
      check("t1_locked_before_last", Unlocked, 0);
      KeyValue = 2'd2;
      KeyPress = 1'b1;
      tick();
      check("t1_unlock_latency", Unlocked, 1);
      check("t1_failcnt", FailCnt, 0);
      KeyPress = 1'b0;
      tick();
      pulse_lock();
      check("t1_relocked", Unlocked, 0);

      // wrong entries, lockout duration, recovery
      enter(CODE_013, 3);
      enter(CODE_013, 3);
      check("t2_failcnt_two", FailCnt, 2);
      check("t2_still_locked", Unlocked, 0);
      press(2'd0);
      press(2'd1);
      KeyValue = 2'd3;
      KeyPress = 1'b1;
      tick();
      check("t2_failcnt_sat", FailCnt, 3);
      cnt = 0;
      while (Alarm && cnt < 2 * LOCKOUT_CYC) begin
         cnt++;
         tick();
      end
      KeyPress = 1'b0;
      check("t2_alarm_cycles", cnt, LOCKOUT_CYC);
      check("t2_fail_cleared", FailCnt, 0);
      tick();
      enter(CODE_012, 3);
      check("t2_open_after_lockout", Unlocked, 1);

      // reprogram to 3,3
      pulse_change();
      check("t3_programming", Programming, 1);
      press(2'd3);
      press(2'd3);
      check("t3_prog_digits", DigitCnt, 2);
      pulse_change();
      check("t3_prog_done", Programming, 0);
      check("t3_still_open", Unlocked, 1);
      pulse_lock();
      enter(CODE_33, 2);
      check("t3_new_code_opens", Unlocked, 1);
      pulse_lock();
      enter(CODE_012, 3);
      check("t3_old_code_fails", Unlocked, 0);
      check("t3_old_code_failcnt", FailCnt, 1);
      pulse_lock();

      // seven-digit auto-commit
      enter(CODE_33, 2);
      pulse_change();
      enter(CODE_SEV, 6);
      check("t4_six_digits", DigitCnt, 6);
      KeyValue = 2'd3;
      KeyPress = 1'b1;
      tick();
      check("t4_autocommit_prog", Programming, 0);
      check("t4_autocommit_open", Unlocked, 1);
      KeyPress = 1'b0;
      tick();
      pulse_lock();
      enter(CODE_SEV, 7);
      check("t4_seven_opens", Unlocked, 1);
      pulse_lock();

      // held key counts once; Lock_It beats a key rise
      KeyValue = 2'd1;
      KeyPress = 1'b1;
      tick(50);
      KeyPress = 1'b0;
      tick();
      check("t5_held_key_once", DigitCnt, 1);
      KeyPress = 1'b1;
      Lock_It = 1'b1;
      tick();
      check("t5_lock_beats_key", DigitCnt, 0);
      KeyPress = 1'b0;
      Lock_It = 1'b0;
      tick();

      // async reset mid-program restores the default code
      enter(CODE_SEV, 7);
      pulse_change();
      press(2'd0);
      press(2'd1);
      check("t6_prog_digits", DigitCnt, 2);
      CLR_n = 1'b0;
      #1;
      check("t6_rst_unlocked", Unlocked, 0);
      check("t6_rst_programming", Programming, 0);
      check("t6_rst_digitcnt", DigitCnt, 0);
      #1;
      CLR_n = 1'b1;
      tick();
      enter(CODE_012, 3);
      check("t6_default_opens", Unlocked, 1);
      pulse_lock();

      // random traffic, keys biased toward the stored code
      for (int i = 0; i < 4000; i++) begin
         KeyPress = 1'($urandom_range(0, 1));
         Change   = ($urandom_range(0, 11) == 0);
         Lock_It  = ($urandom_range(0, 24) == 0);
         if (!m_open && !m_prog && ent_q.size() < pwd_q.size() && $urandom_range(0, 4) != 0)
            KeyValue = 2'(pwd_q[ent_q.size()]);
         else
            KeyValue = 2'($urandom_range(0, 3));
         tick();
      end
      KeyPress = 1'b0;
      Change   = 1'b0;
      Lock_It  = 1'b0;
      tick(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
